// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-port
// data memory. Each access walks IDLE -> SETUP -> STROBE -> CAPTURE -> DONE,
// so memory sees stable line/data for a full cycle before and after the
// one-cycle read or write strobe.
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_line,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic              accept;      // IDLE is taking a new request this cycle
  logic              pick;        // requester chosen if accept is high
  logic              winner;      // requester owning the in-flight access
  logic              prio;        // requester favoured when both ask
  logic              weLatch;
  logic [ADDR_W-1:0] lineLatch;
  logic [DATA_W-1:0] dataLatch;

  logic [1:0]        gntVec;
  logic [1:0]        doneVec;
  logic [DATA_W-1:0] rdataVec [2];

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic plus arbitration decision; a lone request always wins.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    pick      = 1'b0;
    if (req0 && req1) begin
      pick = prio;
    end else begin
      pick = req1;
    end
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept    = 1'b1;
          stateNext = SETUP;
        end
      end
      SETUP:   stateNext = STROBE;
      STROBE:  stateNext = CAPTURE;
      CAPTURE: stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Latch the winner's request at the IDLE sampling edge so later changes on
  // the requester side cannot disturb the access. The latches double as the
  // memory line/data outputs, which therefore hold their value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      winner    <= 1'b0;
      weLatch   <= 1'b0;
      lineLatch <= '0;
      dataLatch <= '0;
    end else if (accept) begin
      winner    <= pick;
      weLatch   <= pick ? we1 : we0;
      lineLatch <= pick ? addr1 : addr0;
      dataLatch <= pick ? wdata1 : wdata0;
    end
  end

  // Round-robin pointer: on entry to DONE, favour the requester not just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (state == CAPTURE) begin
      prio <= ~winner;
    end
  end

  // Per-requester grant, completion pulse and registered read data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    localparam logic ID = 1'(gi);

    assign gntVec[gi]  = (state != IDLE) && (winner == ID);
    assign doneVec[gi] = (state == DONE) && (winner == ID);

    // Only a read by this requester reloads its rdata, on the edge leaving CAPTURE.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdataVec[gi] <= '0;
      end else if ((state == CAPTURE) && !weLatch && (winner == ID)) begin
        rdataVec[gi] <= mem_out;
      end
    end
  end

  assign gnt0      = gntVec[0];
  assign gnt1      = gntVec[1];
  assign done0     = doneVec[0];
  assign done1     = doneVec[1];
  assign rdata0    = rdataVec[0];
  assign rdata1    = rdataVec[1];
  assign busy      = (state != IDLE);
  assign mem_line  = lineLatch;
  assign mem_in    = dataLatch;
  assign mem_read  = (state == STROBE) && !weLatch;
  assign mem_write = (state == STROBE) && weLatch;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for dmem_arbiter against a simple
// registered-output memory; each scenario task checks its own expectations.
module tb_dmem_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_line;
  logic [DATA_W-1:0] mem_in;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_out;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] memArr [2**ADDR_W];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_line(mem_line), .mem_in(mem_in),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_out(mem_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: write on a memWrite edge, read data appears the edge after memRead.
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) memArr[i] = '0;
    mem_out = '0;
  end
  always @(posedge clk) begin
    if (mem_write) memArr[mem_line] <= mem_in;
    if (mem_read)  mem_out <= memArr[mem_line];
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b1; req1 = 1'b0; we0 = 1'b1;
    addr0 = 7'h33; wdata0 = 8'h99;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {gnt0, gnt1, done0, done1, busy});
    end
    checks++;
    if ({mem_read, mem_write} !== 2'b0) begin
      errors++; $display("FAIL reset_strobe got %b want 00", {mem_read, mem_write});
    end
    checks++;
    if (mem_line !== 7'h00 || mem_in !== 8'h00) begin
      errors++; $display("FAIL reset_memport got line=%h in=%h want 00 00", mem_line, mem_in);
    end
    checks++;
    if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      errors++; $display("FAIL reset_rdata got %h %h want 00 00", rdata0, rdata1);
    end
    req0 = 1'b0; we0 = 1'b0;
    rst = 1'b0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_single_write();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h05; wdata0 = 8'hA5;
    @(posedge clk); #1;   // SETUP
    req0 = 1'b0; we0 = 1'b0;
    checks++;
    if ({gnt0, gnt1, busy} !== 3'b101) begin
      errors++; $display("FAIL wr_setup_gnt got gnt0/gnt1/busy=%b want 101", {gnt0, gnt1, busy});
    end
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin
      errors++; $display("FAIL wr_setup_strobe got %b want 00", {mem_read, mem_write});
    end
    @(posedge clk); #1;   // STROBE
    checks++;
    if ({mem_read, mem_write} !== 2'b01 || mem_line !== 7'h05 || mem_in !== 8'hA5) begin
      errors++; $display("FAIL wr_strobe got rd/wr=%b line=%h in=%h want 01 05 a5",
                         {mem_read, mem_write}, mem_line, mem_in);
    end
    @(posedge clk); #1;   // CAPTURE
    checks++;
    if ({mem_read, mem_write, done0} !== 3'b000) begin
      errors++; $display("FAIL wr_capture got rd/wr/done0=%b want 000", {mem_read, mem_write, done0});
    end
    @(posedge clk); #1;   // DONE
    checks++;
    if ({done0, done1, gnt0} !== 3'b101) begin
      errors++; $display("FAIL wr_done got done0/done1/gnt0=%b want 101", {done0, done1, gnt0});
    end
    @(posedge clk); #1;   // IDLE
    checks++;
    if ({done0, gnt0, busy} !== 3'b000 || mem_line !== 7'h05) begin
      errors++; $display("FAIL wr_idle got done0/gnt0/busy=%b line=%h want 000 05",
                         {done0, gnt0, busy}, mem_line);
    end
    $display("write req0 line=05 data=a5");
  endtask

  task automatic test_read_back();
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h05;
    @(posedge clk); #1;   // SETUP
    req1 = 1'b0;
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++; $display("FAIL rd_gnt got gnt0/gnt1=%b want 01", {gnt0, gnt1});
    end
    @(posedge clk); #1;   // STROBE
    checks++;
    if ({mem_read, mem_write} !== 2'b10 || mem_line !== 7'h05) begin
      errors++; $display("FAIL rd_strobe got rd/wr=%b line=%h want 10 05", {mem_read, mem_write}, mem_line);
    end
    @(posedge clk); #1;   // CAPTURE
    checks++;
    if (rdata1 !== 8'h00 || mem_read !== 1'b0) begin
      errors++; $display("FAIL rd_capture got rdata1=%h rd=%b want 00 0", rdata1, mem_read);
    end
    @(posedge clk); #1;   // DONE
    checks++;
    if (done1 !== 1'b1 || done0 !== 1'b0 || rdata1 !== 8'hA5) begin
      errors++; $display("FAIL rd_done got done1=%b done0=%b rdata1=%h want 1 0 a5", done1, done0, rdata1);
    end
    checks++;
    if (rdata0 !== 8'h00) begin
      errors++; $display("FAIL rd_other got rdata0=%h want 00", rdata0);
    end
    @(posedge clk); #1;   // IDLE
    checks++;
    if (done1 !== 1'b0 || rdata1 !== 8'hA5) begin
      errors++; $display("FAIL rd_hold got done1=%b rdata1=%h want 0 a5", done1, rdata1);
    end
    $display("read req1 line=05 data=%h", rdata1);
  endtask

  task automatic test_stale_inputs();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h10; wdata0 = 8'h33;
    @(posedge clk); #1;   // SETUP
    req0 = 1'b0; we0 = 1'b0; addr0 = 7'h20; wdata0 = 8'h44;
    @(posedge clk); #1;   // STROBE
    checks++;
    if (mem_write !== 1'b1 || mem_line !== 7'h10 || mem_in !== 8'h33) begin
      errors++; $display("FAIL stale_strobe got wr=%b line=%h in=%h want 1 10 33", mem_write, mem_line, mem_in);
    end
    @(posedge clk); #1;   // CAPTURE
    @(posedge clk); #1;   // DONE
    checks++;
    if (done0 !== 1'b1) begin
      errors++; $display("FAIL stale_done got done0=%b want 1", done0);
    end
    checks++;
    if (rdata1 !== 8'hA5 || rdata0 !== 8'h00) begin
      errors++; $display("FAIL write_no_rdata got rdata0=%h rdata1=%h want 00 a5", rdata0, rdata1);
    end
    @(posedge clk); #1;   // IDLE
    $display("write req0 line=10 data=33 (inputs changed after sampling)");
  endtask

  task automatic test_contention();
    int    nDone;
    logic  order [4];
    int    doneAt [4];
    nDone = 0;
    @(negedge clk);
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 7'h10; addr1 = 7'h05;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (gnt0 && gnt1) begin
        errors++; $display("FAIL cont_excl cycle %0d got gnt0=1 gnt1=1 want not both", i);
      end
      if (done0 || done1) begin
        if (nDone < 4) begin
          order[nDone]  = done1;
          doneAt[nDone] = i;
        end
        nDone++;
        $display("contention done req%0d at cycle %0d", done1 ? 1 : 0, i);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (nDone !== 4) begin
      errors++; $display("FAIL cont_count got %0d dones want 4", nDone);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (order[k] !== k[0] || doneAt[k] !== 4 + 5 * k) begin
          errors++; $display("FAIL cont_order slot %0d got req%0d at cycle %0d want req%0d at cycle %0d",
                             k, order[k], doneAt[k], k % 2, 4 + 5 * k);
        end
      end
    end
    checks++;
    if (rdata0 !== 8'h33 || rdata1 !== 8'hA5) begin
      errors++; $display("FAIL cont_rdata got %h %h want 33 a5", rdata0, rdata1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    // Seed line 7F with a known value.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h7F; wdata0 = 8'h11;
    @(posedge clk); #1;
    req0 = 1'b0; we0 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    $display("write req0 line=7f data=11");
    // Second write, aborted by reset while in SETUP.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h7F; wdata0 = 8'hEE;
    @(posedge clk); #1;   // SETUP
    req0 = 1'b0; we0 = 1'b0;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL abort_setup got gnt0=%b want 1", gnt0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mem_write, mem_read, busy, gnt0, gnt1} !== 5'b0) begin
      errors++; $display("FAIL abort_after got wr/rd/busy/gnt0/gnt1=%b want 00000",
                         {mem_write, mem_read, busy, gnt0, gnt1});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_write, done0} !== 2'b00) begin
      errors++; $display("FAIL abort_nostrobe got wr/done0=%b want 00", {mem_write, done0});
    end
    $display("write req0 line=7f data=ee aborted by reset");
    // Read back line 7F: must still hold the seeded value.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h7F;
    @(posedge clk); #1;
    req1 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done1 !== 1'b1 || rdata1 !== 8'h11) begin
      errors++; $display("FAIL abort_readback got done1=%b rdata1=%h want 1 11", done1, rdata1);
    end
    $display("read req1 line=7f data=%h", rdata1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_stale_inputs();
    test_contention();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
